// File: rtl/fys_perm_stream.sv
// fys_perm_stream: kicks off one shuffle on the external Fisher-Yates core, then
// reads its permutation memory in address order and streams the entries out over
// a valid/ready interface. A 2-entry FIFO is used as skid buffering. The read
// issue logic counts the FIFO occupancy plus the read in flight, so the FIFO
// cannot overflow.
module fys_perm_stream #(
   parameter int m = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic [63:0]   seed_in,
   output logic          busy,
   output logic          fys_start,
   output logic [63:0]   fys_seed,
   input  logic          fys_done,
   output logic          fys_rd_en,
   output logic [m-1:0]  fys_rd_addr,
   input  logic [m-1:0]  fys_data,
   output logic          perm_valid,
   input  logic          perm_ready,
   output logic [m-1:0]  perm_data,
   output logic          perm_last,
   output logic          done
);

   localparam logic [m:0]   NUM_ENTRIES = {1'b1, {m{1'b0}}};
   localparam logic [m-1:0] LAST_ADDR   = {m{1'b1}};

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      READ,
      FIN
   } state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                start_q, start_d;
   logic                done_q, done_d;
   logic [63:0]         seed_q, seed_d;
   logic [m-1:0]        addr_q, addr_d;
   logic [m:0]          issued_q, issued_d;
   logic                inflight_q, inflight_d;
   logic                inflight_last_q, inflight_last_d;
   logic [1:0][m-1:0]   fifo_data_q, fifo_data_d;
   logic [1:0]          fifo_last_q, fifo_last_d;
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          count_q, count_d;

   logic                fifo_pop;
   logic                fifo_push;
   logic                rd_en;
   logic [2:0]          occ_after_pop;
   logic                head_last;

   // Read issue: allow a new read only if it will still have a FIFO slot when it returns
   always_comb begin
      fifo_pop      = (count_q != 2'd0) && perm_ready;
      fifo_push     = inflight_q;
      head_last     = fifo_last_q[rd_ptr_q];
      occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fifo_pop};
      rd_en         = (state_q == READ) && (occ_after_pop < 3'd2) && (issued_q < NUM_ENTRIES);
   end

   // Next-state computation for the control FSM, read counters and FIFO
   always_comb begin
      state_d         = state_q;
      busy_d          = busy_q;
      start_d         = 1'b0;
      done_d          = 1'b0;
      seed_d          = seed_q;
      addr_d          = addr_q;
      issued_d        = issued_q;
      inflight_d      = rd_en;
      inflight_last_d = rd_en && (addr_q == LAST_ADDR);
      fifo_data_d     = fifo_data_q;
      fifo_last_d     = fifo_last_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               state_d  = START;
               seed_d   = seed_in;
               busy_d   = 1'b1;
               start_d  = 1'b1;
               addr_d   = '0;
               issued_d = '0;
            end
         end
         START: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (fys_done) begin
               state_d = READ;
            end
         end
         READ: begin
            if (fifo_pop && head_last) begin
               state_d = FIN;
               done_d  = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (rd_en) begin
         addr_d   = addr_q + 1'b1;
         issued_d = issued_q + 1'b1;
      end

      if (fifo_push) begin
         fifo_data_d[wr_ptr_q] = fys_data;
         fifo_last_d[wr_ptr_q] = inflight_last_q;
         wr_ptr_d              = ~wr_ptr_q;
      end
      if (fifo_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
   end

   // State register; reset drops any pending reads and buffered entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         busy_q          <= 1'b0;
         start_q         <= 1'b0;
         done_q          <= 1'b0;
         seed_q          <= '0;
         addr_q          <= '0;
         issued_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_data_q     <= '0;
         fifo_last_q     <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         busy_q          <= busy_d;
         start_q         <= start_d;
         done_q          <= done_d;
         seed_q          <= seed_d;
         addr_q          <= addr_d;
         issued_q        <= issued_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         fifo_data_q     <= fifo_data_d;
         fifo_last_q     <= fifo_last_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   // Output drive; the address bus and the stream sideband are zero when idle
   always_comb begin
      busy        = busy_q;
      fys_start   = start_q;
      done        = done_q;
      fys_seed    = seed_q;
      fys_rd_en   = rd_en;
      fys_rd_addr = rd_en ? addr_q : '0;
      perm_valid  = (count_q != 2'd0);
      perm_data   = perm_valid ? fifo_data_q[rd_ptr_q] : '0;
      perm_last   = perm_valid && head_last;
   end

endmodule

// File: doc/fys_perm_stream.md
FYS_PERM_STREAM -- requirements
Module: fys_perm_stream

Interface
REQ-001 Parameter: m, default 13, index width; the permutation has 2^m entries.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  single-cycle request to generate and stream one permutation.
REQ-005 seed_in  input  64  seed, sampled in the cycle req is accepted.
REQ-006 busy  output  1  high from req acceptance until the done pulse, inclusive.
REQ-007 fys_start  output  1  one-cycle start pulse to the shuffle core.
REQ-008 fys_seed  output  64  registered seed to the shuffle core.
REQ-009 fys_done  input  1  shuffle-complete level from the shuffle core.
REQ-010 fys_rd_en  output  1  read enable to the shuffle core memory.
REQ-011 fys_rd_addr  output  m  read address to the shuffle core memory.
REQ-012 fys_data  input  m  read data, valid the cycle after fys_rd_en.
REQ-013 perm_valid  output  1  stream beat valid.
REQ-014 perm_ready  input  1  downstream accepts the beat.
REQ-015 perm_data  output  m  permuted index, entry order 0..2^m-1.
REQ-016 perm_last  output  1  high with the beat carrying entry 2^m-1.
REQ-017 done  output  1  one-cycle pulse after the final beat handshake.

Function
REQ-018 The FSM SHALL have states IDLE, START, WAIT, READ and FIN.
REQ-019 In IDLE, req=1 SHALL latch seed_in into fys_seed and move to START; req outside IDLE SHALL be ignored.
REQ-020 START SHALL last exactly one cycle with fys_start=1, then move to WAIT.
REQ-021 WAIT SHALL move to READ on the first cycle fys_done=1; fys_done SHALL be ignored in all other states.
REQ-022 READ SHALL issue reads at addresses 0,1,...,2^m-1 in order, each exactly once; the address counter is m bits and the issued counter is m+1 bits.
REQ-023 fys_rd_en SHALL be high only in READ, and only when (fifo occupancy + in-flight reads - pop this cycle) < 2 and issued < 2^m.
REQ-024 Returned fys_data SHALL be written into a 2-entry FIFO at the end of the return cycle.
REQ-025 perm_valid SHALL assert no earlier than 2 cycles after the corresponding read issue.
REQ-026 A beat transfers when perm_valid && perm_ready.
REQ-027 While perm_valid && !perm_ready, perm_data and perm_last SHALL hold stable.
REQ-028 With perm_ready held at 1, the block SHALL sustain one beat per cycle, delivering 2^m consecutive beats.
REQ-029 The FIFO SHALL never overflow; reads SHALL stall (fys_rd_en=0) while it is full.
REQ-030 Transfer of the beat with perm_last=1 SHALL move to FIN.
REQ-031 FIN SHALL assert done for one cycle, then return to IDLE with busy=0.
REQ-032 fys_rd_addr SHALL be 0 whenever fys_rd_en=0.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, clear the FIFO, counters and in-flight flag, and drive busy, fys_start, fys_rd_en, perm_valid, perm_last and done to 0, and fys_seed and fys_rd_addr to 0.
REQ-034 Reset mid-operation SHALL discard all pending data; the next req SHALL restart with a fresh fys_start pulse (the shuffle core has no reset of its own).

Verification
REQ-035 Assert rst_n=0 during READ -> all outputs 0 in the same cycle; after release, no beats until a new req.
REQ-036 m=4, seed_in=64'h1, perm_ready=1, req -> fys_start pulses one cycle after req; after fys_done, 16 back-to-back beats whose values are a permutation of 0..15; perm_last on beat 16; done the cycle after.
REQ-037 m=4, perm_ready toggling 1,0,1,0 -> exactly 16 beats, no duplicates or losses; data stable while stalled.
REQ-038 perm_ready=0 for 10 cycles mid-stream -> at most 2 reads outstanding, then fys_rd_en=0; streaming resumes without a gap in the address order.
REQ-039 req pulsed during WAIT and during READ -> ignored, with no second fys_start.
REQ-040 Two runs with seed_in=64'hDEADBEEF -> identical 16-beat sequences; a different seed gives a different sequence.
